rv_alu_mc: RTL and testbench

//  Parametrised multi-cycle RV integer ALU; successor to the single-cycle 4-bit-opsel ALU.

---
 rtl/rv_alu_mc.sv | 186 ++++++++++++++++++
 tb/tb_rv_alu_mc.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rv_alu_mc.sv
// Multi-cycle RV integer ALU: 1-cycle simple ops; shifts iterate SHIFT_STEP bits per cycle.
// Latency: 1 cycle for non-shift ops, max(1, ceil(n/SHIFT_STEP)) cycles for shifts.
// Backpressure: result held while out_valid && !out_ready; in_ready low in SHIFT or when output blocked.
module rv_alu_mc #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_op,
    input  logic            in_b_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_err,
    output logic            busy
);

    // Shift counts need SW bits; one extra bit lets SHIFT_STEP == XLEN be represented.
    localparam int SW = $clog2(XLEN);
    localparam logic [SW:0] STEP_MAX = (SW+1)'(SHIFT_STEP);

    localparam logic [1:0] SK_SLL = 2'd0;
    localparam logic [1:0] SK_SRL = 2'd1;
    localparam logic [1:0] SK_SRA = 2'd2;

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t          state;
    state_t          state_nxt;

    logic [XLEN-1:0] op_b;
    logic            accept;
    logic            is_shift;
    logic [1:0]      in_kind;

    logic [XLEN-1:0] alu_res;
    logic            alu_err;

    // Shifter working state; only written when a shift is accepted or iterating.
    logic [XLEN-1:0] work;
    logic [SW:0]     rem;
    logic [1:0]      kind;

    logic [SW:0]     n_ext;
    logic [SW:0]     step0;
    logic [SW:0]     rem0;
    logic [XLEN-1:0] work_first;

    logic [SW:0]     step_cur;
    logic [SW:0]     rem_left;
    logic [XLEN-1:0] work_step;

    // One bounded shifter step, shared by the first and the iterating steps.
    function automatic logic [XLEN-1:0] shift_by(input logic [1:0] k,
                                                 input logic [XLEN-1:0] val,
                                                 input logic [SW:0] amt);
        logic [XLEN-1:0] r;
        case (k)
            SK_SRL:  r = val >> amt;
            SK_SRA:  r = $unsigned($signed(val) >>> amt);
            default: r = val << amt;
        endcase
        return r;
    endfunction

    assign op_b     = in_b_imm ? in_imm : in_rs2;
    assign accept   = in_valid && in_ready;
    assign is_shift = (in_op == 4'd7) || (in_op == 4'd8) || (in_op == 4'd9);

    // Map shift opcode to shifter direction/kind.
    always_comb begin
        in_kind = SK_SLL;
        if (in_op == 4'd8)
            in_kind = SK_SRL;
        else if (in_op == 4'd9)
            in_kind = SK_SRA;
    end

    // First shift step is done in the accept cycle so short shifts finish in one cycle.
    always_comb begin
        n_ext      = {1'b0, op_b[SW-1:0]};
        step0      = (n_ext > STEP_MAX) ? STEP_MAX : n_ext;
        rem0       = n_ext - step0;
        work_first = shift_by(in_kind, in_rs1, step0);
    end

    // Subsequent iterations while in SHIFT.
    always_comb begin
        step_cur  = (rem > STEP_MAX) ? STEP_MAX : rem;
        rem_left  = rem - step_cur;
        work_step = shift_by(kind, work, step_cur);
    end

    // Single-cycle operations; reserved opcodes yield zero with an error flag.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (in_op)
            4'd0:    alu_res = in_rs1 + op_b;
            4'd1:    alu_res = in_rs1 - op_b;
            4'd2:    alu_res = in_rs1 & op_b;
            4'd3:    alu_res = in_rs1 | op_b;
            4'd4:    alu_res = in_rs1 ^ op_b;
            4'd5:    alu_res = {{(XLEN-1){1'b0}}, ($signed(in_rs1) < $signed(op_b))};
            4'd6:    alu_res = {{(XLEN-1){1'b0}}, (in_rs1 < op_b)};
            4'd10:   alu_res = in_imm;
            4'd11:   alu_res = in_pc + in_imm;
            4'd7, 4'd8, 4'd9: alu_res = '0;
            default: alu_err = 1'b1;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // FSM next state: enter SHIFT only for shifts that need more than one step.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept && is_shift && (rem0 != '0)) state_nxt = S_SHIFT;
            S_SHIFT: if (rem_left == '0)                     state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: no new request while iterating or while the output is blocked.
    always_comb begin
        in_ready = (state == S_IDLE) && (!out_valid || out_ready);
        busy     = (state == S_SHIFT);
    end

    // Result and shifter datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_err    <= 1'b0;
            work       <= '0;
            rem        <= '0;
            kind       <= SK_SLL;
        end else if (state == S_IDLE && accept) begin
            if (is_shift) begin
                work <= work_first;
                rem  <= rem0;
                kind <= in_kind;
                if (rem0 == '0) begin
                    out_result <= work_first;
                    out_err    <= 1'b0;
                    out_valid  <= 1'b1;
                end else begin
                    // Any previous result drains on this same edge.
                    out_err   <= 1'b0;
                    out_valid <= 1'b0;
                end
            end else begin
                out_result <= alu_res;
                out_err    <= alu_err;
                out_valid  <= 1'b1;
            end
        end else if (state == S_SHIFT) begin
            work <= work_step;
            rem  <= rem_left;
            if (rem_left == '0) begin
                out_result <= work_step;
                out_err    <= 1'b0;
                out_valid  <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_alu_mc.sv
// Directed bench for rv_alu_mc (XLEN=32, SHIFT_STEP=4).
// Inputs change and outputs are sampled on the falling clock edge.
// Every check is an immediate assertion that counts evaluations and failures.
module tb_rv_alu_mc;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      in_op;
    logic            in_b_imm;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            out_err;
    logic            busy;

    int n_assert = 0;
    int n_fail   = 0;
    int k;
    int busy_cnt;

    rv_alu_mc #(.XLEN(XLEN), .SHIFT_STEP(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_b_imm   (in_b_imm),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .in_pc      (in_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_err    (out_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request at a falling edge, let it be accepted on the next rising edge.
    task automatic issue(input logic [3:0] op, input logic bimm, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc);
        in_valid = 1'b1;
        in_op    = op;
        in_b_imm = bimm;
        in_rs1   = a;
        in_rs2   = b;
        in_imm   = imm;
        in_pc    = pc;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 4'd0;
        in_b_imm  = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_imm    = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;

        // ADD wraps; accepted on the first edge after reset release
        issue(4'd0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
        chk("add_valid", out_valid, 1);
        chk("add_wrap", out_result, 32'h0000_0000);
        chk("add_err", out_err, 0);
        chk("ready_while_draining", in_ready, 1);

        issue(4'd1, 1'b0, 32'h0, 32'h1, 32'h0, 32'h0);
        chk("sub_wrap", out_result, 32'hFFFF_FFFF);

        // SLT vs SLTU with immediate operand (rs2 must be ignored)
        issue(4'd5, 1'b1, 32'h8000_0000, 32'h5, 32'h1, 32'h0);
        chk("slt_signed", out_result, 32'h1);
        issue(4'd6, 1'b1, 32'h8000_0000, 32'h5, 32'h1, 32'h0);
        chk("sltu_unsigned", out_result, 32'h0);

        issue(4'd2, 1'b0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0, 32'h0);
        chk("and", out_result, 32'h00F0_1234);

        // SRA by 31: 8 shift steps, 7 busy cycles
        issue(4'd9, 1'b0, 32'h8000_0000, 32'd31, 32'h0, 32'h0);
        chk("sra_busy", busy, 1);
        chk("sra_in_ready", in_ready, 0);
        chk("sra_no_valid", out_valid, 0);
        k        = 1;
        busy_cnt = 0;
        while (!out_valid && k < 20) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        chk("sra_latency", k, 8);
        chk("sra_busy_cycles", busy_cnt, 7);
        chk("sra_result", out_result, 32'hFFFF_FFFF);
        chk("sra_busy_done", busy, 0);

        // Shift boundaries: n=0, n=STEP, upper amount bits ignored
        issue(4'd7, 1'b0, 32'h1234_5678, 32'd0, 32'h0, 32'h0);
        chk("sll0_valid", out_valid, 1);
        chk("sll0_result", out_result, 32'h1234_5678);
        chk("sll0_busy", busy, 0);
        issue(4'd8, 1'b1, 32'hF000_0000, 32'd0, 32'd4, 32'h0);
        chk("srl4_valid", out_valid, 1);
        chk("srl4_result", out_result, 32'h0F00_0000);
        issue(4'd7, 1'b0, 32'h1, 32'h21, 32'h0, 32'h0);
        chk("sll_amt_mask", out_result, 32'h2);

        // Backpressure for two cycles with an XOR waiting, then drain and accept together
        issue(4'd0, 1'b0, 32'd5, 32'd7, 32'h0, 32'h0);
        chk("add_bp_result", out_result, 32'd12);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 4'd4;
        in_b_imm  = 1'b0;
        in_rs1    = 32'hF0F0_F0F0;
        in_rs2    = 32'hFF00_FF00;
        #1;
        chk("bp_in_ready", in_ready, 0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_result", out_result, 32'd12);
            chk("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("xor_no_bubble_valid", out_valid, 1);
        chk("xor_result", out_result, 32'h0FF0_0FF0);

        // Asynchronous reset in the middle of SRL by 20
        issue(4'd8, 1'b0, 32'hFFFF_FFFF, 32'd20, 32'h0, 32'h0);
        chk("srl20_busy", busy, 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_result", out_result, 0);
        @(negedge clk);
        rst = 1'b0;
        issue(4'd3, 1'b0, 32'h0000_00F0, 32'h0000_000F, 32'h0, 32'h0);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_or", out_result, 32'h0000_00FF);
        chk("post_rst_busy", busy, 0);

        // Reserved opcode, AUIPC, LUI
        issue(4'd13, 1'b0, 32'h1, 32'h2, 32'h3, 32'h4);
        chk("rsvd_valid", out_valid, 1);
        chk("rsvd_err", out_err, 1);
        chk("rsvd_result", out_result, 0);
        issue(4'd11, 1'b1, 32'h0, 32'h0, 32'h2000, 32'h1000);
        chk("auipc_result", out_result, 32'h3000);
        chk("auipc_err", out_err, 0);
        issue(4'd10, 1'b1, 32'h5555_5555, 32'h0, 32'hABCD_E000, 32'h0);
        chk("lui_result", out_result, 32'hABCD_E000);
        @(posedge clk);
        @(negedge clk);
        chk("drained_valid", out_valid, 0);
        chk("drained_err", out_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
